// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if: serial line, shift-register strobes and parallel valid/ready bundle.
interface serial_frame_rx_if #(parameter int W = 8);
  logic rx, clr, shl, shl_in, valid, ready, frame_err, overrun;
  logic [W-1:0] data;
  modport master(input rx, ready, output clr, shl, shl_in, data, valid, frame_err, overrun);
  modport slave(output rx, ready, input clr, shl, shl_in, data, valid, frame_err, overrun);
endinterface

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: async-serial framer driving a downstream shift register plus a valid/ready frame output.
module serial_frame_rx #(
  parameter int W = 8,
  parameter int DIV = 4
) (
  input logic clk,
  input logic rst_n,
  serial_frame_rx_if.master bus
);
  localparam int DW = $clog2(DIV);
  localparam int BW = $clog2(W);
  localparam logic [DW-1:0] HALF = DW'(DIV / 2 - 1);
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BLAST = BW'(W - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t state;
  logic [DW-1:0] div;
  logic [BW-1:0] bcnt;
  logic [W-1:0] shreg, data;
  logic clr, shl, shl_in, valid, frame_err, overrun;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      div <= '0;
      bcnt <= '0;
      shreg <= '0;
      data <= '0;
      valid <= 1'b0;
      clr <= 1'b0;
      shl <= 1'b0;
      shl_in <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      clr <= 1'b0;
      shl <= 1'b0;
      shl_in <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
      if (valid && bus.ready) valid <= 1'b0;
      case (state)
        IDLE: if (!bus.rx) state <= START;
        START: begin
          div <= div == HALF ? '0 : div + 1'b1;
          if (div == HALF) begin
            state <= bus.rx ? IDLE : DATA;
            bcnt <= '0;
            clr <= !bus.rx;
          end
        end
        DATA: begin
          div <= div == LAST ? '0 : div + 1'b1;
          if (div == LAST) begin
            shreg <= {shreg[W-2:0], bus.rx};
            shl <= 1'b1;
            shl_in <= bus.rx;
            bcnt <= bcnt + 1'b1;
            if (bcnt == BLAST) state <= STOP;
          end
        end
        STOP: begin
          div <= div == LAST ? '0 : div + 1'b1;
          if (div == LAST) begin
            state <= bus.rx ? IDLE : BREAK;
            frame_err <= !bus.rx;
            // a handshake on this same edge frees the slot for the new frame
            if (bus.rx && (!valid || bus.ready)) begin
              data <= shreg;
              valid <= 1'b1;
            end
            overrun <= bus.rx && valid && !bus.ready;
          end
        end
        BREAK: if (bus.rx) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.clr = clr;
  assign bus.shl = shl;
  assign bus.shl_in = shl_in;
  assign bus.data = data;
  assign bus.valid = valid;
  assign bus.frame_err = frame_err;
  assign bus.overrun = overrun;
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed and random frames checked against a timing/handshake model.
module tb_serial_frame_rx;
  localparam int W = 8, DIV = 4, H = DIV / 2;
  logic clk = 1'b0, rst_n = 1'b0;
  int cyc = 0, n_assert = 0, n_fail = 0;
  int clr_n, clr_cyc, fe_n, ov_n, vrise;
  logic valid_q = 1'b0;
  logic bits[$];
  int shl_cyc[$];
  logic [W-1:0] m_data;
  logic m_valid;

  serial_frame_rx_if #(.W(W)) bus();
  serial_frame_rx #(.W(W), .DIV(DIV)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    n_assert += 2;
    assert (!(bus.clr && bus.shl)) else begin n_fail++; $error("FAIL clr_shl_overlap at cycle %0d: clr=%b shl=%b, required not both", cyc, bus.clr, bus.shl); end
    assert (bus.shl || !bus.shl_in) else begin n_fail++; $error("FAIL shl_in_idle at cycle %0d: shl_in=%b, required 0", cyc, bus.shl_in); end
    if (bus.clr) begin clr_n++; clr_cyc = cyc; end
    if (bus.shl) begin bits.push_back(bus.shl_in); shl_cyc.push_back(cyc); end
    if (bus.frame_err) fe_n++;
    if (bus.overrun) ov_n++;
    if (bus.valid && !valid_q) vrise = cyc;
    valid_q = bus.valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_assert++;
    assert (got === expv) else begin n_fail++; $error("FAIL %s: got %0h expected %0h", tag, got, expv); end
  endtask

  task automatic clear_mon();
    clr_n = 0; fe_n = 0; ov_n = 0; vrise = -1;
    bits.delete(); shl_cyc.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_frame(input logic [W-1:0] v, input logic stop, input int ncyc, input bit rdy_stop, output int e0);
    logic [W+1:0] line;
    line = {1'b0, v, stop};
    e0 = cyc + 1;
    for (int c = 0; c < ncyc; c++) begin
      bus.rx = line[W+1-c/DIV];
      if (rdy_stop) bus.ready = (cyc + 1 == e0 + H + DIV * (W + 1));
      tick(1);
    end
  endtask

  task automatic run_frame(input logic [W-1:0] v, input logic stop, input logic r, input bit rdy_stop, input int low_hold);
    int e0;
    logic prev_v, acc, exp_ov;
    clear_mon();
    bus.ready = r;
    prev_v = m_valid && !r;
    acc = stop && (!prev_v || rdy_stop);
    exp_ov = stop && !acc;
    drive_frame(v, stop, DIV * (W + 2), rdy_stop, e0);
    bus.ready = r;
    tick(low_hold);
    bus.rx = 1'b1;
    tick(3);
    if (acc) begin m_data = v; m_valid = !r; end else m_valid = prev_v;
    chk($sformatf("clr_count_%h", v), clr_n, 1);
    chk($sformatf("clr_time_%h", v), clr_cyc, e0 + H);
    chk($sformatf("shl_count_%h", v), bits.size(), W);
    for (int i = 0; i < W && i < bits.size(); i++) begin
      chk($sformatf("shl_in_%h_bit%0d", v, i), 32'(bits[i]), 32'(v[W-1-i]));
      chk($sformatf("shl_time_%h_bit%0d", v, i), shl_cyc[i], e0 + H + DIV * (i + 1));
    end
    chk($sformatf("frame_err_%h", v), fe_n, 32'(!stop));
    chk($sformatf("overrun_%h", v), ov_n, 32'(exp_ov));
    chk($sformatf("valid_%h", v), 32'(bus.valid), 32'(m_valid));
    chk($sformatf("data_%h", v), 32'(bus.data), 32'(m_data));
    if (acc && !prev_v) chk($sformatf("valid_rise_%h", v), vrise, e0 + H + DIV * (W + 1));
  endtask

  initial begin
    int e0;
    logic [W-1:0] rv;
    logic rs, rr;
    bus.rx = 1'b1; bus.ready = 1'b0;
    m_valid = 1'b0; m_data = '0;
    clear_mon();
    tick(3);
    chk("reset_outputs", 32'({bus.clr, bus.shl, bus.shl_in, bus.frame_err, bus.overrun, bus.valid, bus.data}), 0);
    rst_n = 1'b1;
    tick(3);
    chk("idle_quiet", clr_n + bits.size() + fe_n + ov_n, 0);
    run_frame(8'hA5, 1'b1, 1'b1, 1'b0, 0);
    // one-clock low pulse must be rejected at the mid-bit check
    clear_mon();
    bus.ready = 1'b0;
    bus.rx = 1'b0;
    tick(1);
    bus.rx = 1'b1;
    tick(DIV + 2);
    chk("glitch_clr", clr_n, 0);
    chk("glitch_shl", bits.size(), 0);
    run_frame(8'h5A, 1'b1, 1'b1, 1'b0, 0);
    run_frame(8'hFF, 1'b0, 1'b0, 1'b0, 10);
    run_frame(8'h3C, 1'b1, 1'b0, 1'b0, 0);
    run_frame(8'hC3, 1'b1, 1'b0, 1'b0, 0);
    bus.ready = 1'b1;
    tick(1);
    bus.ready = 1'b0;
    m_valid = 1'b0;
    tick(1);
    chk("single_ready_valid", 32'(bus.valid), 0);
    chk("single_ready_data", 32'(bus.data), 32'h3C);
    run_frame(8'h3C, 1'b1, 1'b0, 1'b0, 0);
    run_frame(8'hC3, 1'b1, 1'b0, 1'b1, 0);
    // reset mid-frame, right after data bit 3 has been shifted out
    clear_mon();
    bus.ready = 1'b0;
    drive_frame(8'h81, 1'b1, H + 4 * DIV + 1, 1'b0, e0);
    chk("pre_reset_shl", 32'(bus.shl), 1);
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_outputs", 32'({bus.clr, bus.shl, bus.shl_in, bus.frame_err, bus.overrun, bus.valid, bus.data}), 0);
    bus.rx = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_valid = 1'b0; m_data = '0;
    clear_mon();
    tick(4);
    chk("post_reset_quiet", clr_n + bits.size() + fe_n + ov_n, 0);
    run_frame(8'h81, 1'b1, 1'b0, 1'b0, 0);
    for (int n = 0; n < 24; n++) begin
      rv = W'($urandom);
      rs = $urandom_range(0, 4) != 0;
      rr = 1'($urandom_range(0, 1));
      run_frame(rv, rs, rr, 1'b0, rs ? 0 : int'($urandom_range(0, 6)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
